// File: rtl/fifo_rd_stream_ctrl.sv
// Read-side controller for the async packet FIFO: pops words, captures the
// sync-read RAM output into a 3-entry buffer, streams it on valid/ready and
// executes drop verdicts by flushing the remainder of the current packet.
module fifo_rd_stream_ctrl #(
  parameter int DATAW = 64,
  parameter int CNTW  = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  output logic             rincr,
  input  logic [DATAW:0]   rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DATAW-1:0] m_data,
  output logic             m_last,
  input  logic             flush,
  output logic [CNTW-1:0]  pkt_cnt,
  output logic [CNTW-1:0]  drop_cnt
);

  typedef enum logic {RUN, DROP} state_t;

  state_t         state, state_nxt;
  logic [DATAW:0] mem [3];
  logic [2:0]     vld;            // per-slot occupancy
  logic [1:0]     rd_ptr, wr_ptr;
  logic [1:0]     buf_cnt;
  logic [2:0]     occ;
  logic           inflight;
  logic           last_seen;
  logic           hs, flush_acc, wr_en, arr_last;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign buf_cnt   = 2'(vld[0]) + 2'(vld[1]) + 2'(vld[2]);
  assign occ       = {1'b0, buf_cnt} + {2'b00, inflight};
  assign m_valid   = |vld;
  assign hs        = m_valid & m_ready;
  assign m_data    = m_valid ? mem[rd_ptr][DATAW-1:0] : '0;
  assign m_last    = m_valid & mem[rd_ptr][DATAW];
  assign arr_last  = rdata[DATAW];
  // A buffered end-of-packet means the packet is already complete: flush must not touch it.
  assign last_seen = |(vld & {mem[2][DATAW], mem[1][DATAW], mem[0][DATAW]});
  // While dropping, pop freely; otherwise never commit more words than the buffer can hold.
  assign rincr     = ~rempty & ((state == DROP) | (occ < 3'd3));

  // State register
  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) state <= RUN;
    else       state <= state_nxt;
  end

  // Next state, flush acceptance and buffer write decision
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    flush_acc = 1'b0;
    case (state)
      RUN: begin
        flush_acc = flush & ~last_seen;
        if (flush_acc) begin
          // The arriving word is discarded; if it closes the packet there is nothing left to drop.
          if (!(inflight & arr_last)) state_nxt = DROP;
        end else begin
          wr_en = inflight;
        end
      end
      DROP: begin
        if (inflight & arr_last) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // RAM read-latency tracker: a pop this clk delivers rdata next clk
  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) inflight <= 1'b0;
    else       inflight <= rincr;
  end

  // Buffer occupancy and pointers; handshake completes before a flush clears the rest
  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      vld    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush_acc) begin
      vld    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (hs) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= ptr_inc(rd_ptr);
      end
      if (wr_en) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
    end
  end

  // Buffer storage (data only, no reset needed)
  always_ff @(posedge rclk) begin
    if (wr_en) mem[wr_ptr] <= rdata;
  end

  // Saturating packet and drop counters
  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (hs && m_last && !(&pkt_cnt))   pkt_cnt  <= pkt_cnt + CNTW'(1);
      if (flush_acc && !(&drop_cnt))     drop_cnt <= drop_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream_ctrl.sv
// Bench for fifo_rd_stream_ctrl: a FIFO source model feeds the DUT, a queue-based
// reference model predicts outputs every cycle, directed scenarios pin literal values.
module tb_fifo_rd_stream_ctrl;
  localparam int DATAW = 16;
  localparam int CNTW  = 4;
  localparam int SAT   = 15;

  logic             rclk = 1'b0;
  logic             rrst = 1'b0;
  logic             rempty = 1'b1;
  logic             rincr;
  logic [DATAW:0]   rdata = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [DATAW-1:0] m_data;
  logic             m_last;
  logic             flush = 1'b0;
  logic [CNTW-1:0]  pkt_cnt, drop_cnt;

  fifo_rd_stream_ctrl #(.DATAW(DATAW), .CNTW(CNTW)) dut (
    .rclk(rclk), .rrst(rrst), .rempty(rempty), .rincr(rincr), .rdata(rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .flush(flush), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 rclk = ~rclk;

  int nvec = 0;
  int nerr = 0;

  // source FIFO and pending RAM word
  logic [DATAW:0] src_q[$];
  logic [DATAW:0] pend;
  bit             pend_vld;
  // reference model
  logic [DATAW:0] mq[$];
  bit             mdrop, minfl, exp_rincr;
  int             mpkt, mdcnt;
  // observation
  logic [DATAW:0] dlv[$];
  logic [31:0]    rv_log, mv_log;
  int             cyc_idx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete(); mdrop = 0; minfl = 0; mpkt = 0; mdcnt = 0;
    pend_vld = 0;
  endtask

  task automatic model_step(input bit fl, input bit rdy, input logic [DATAW:0] w);
    bit ls = 0;
    foreach (mq[i]) if (mq[i][DATAW]) ls = 1;
    if (mq.size() != 0 && rdy) begin
      if (mq[0][DATAW] && mpkt < SAT) mpkt++;
      void'(mq.pop_front());
    end
    if (!mdrop && fl && !ls) begin
      if (mdcnt < SAT) mdcnt++;
      mq.delete();
      mdrop = !(minfl && w[DATAW]);
    end else if (mdrop) begin
      if (minfl && w[DATAW]) mdrop = 0;
    end else if (minfl) begin
      mq.push_back(w);
    end
    minfl = exp_rincr;
  endtask

  // one clock: drive, compare against model, advance source and model
  task automatic cyc(input bit fl, input bit rdy, input bit hold);
    logic [DATAW:0] w;
    @(negedge rclk);
    flush   = fl;
    m_ready = rdy;
    rempty  = (!rrst) || hold || (src_q.size() == 0);
    rdata   = pend_vld ? pend : (DATAW+1)'($urandom);
    w       = rdata;
    #1;
    exp_rincr = !rempty && (mdrop || (mq.size() + int'(minfl)) < 3);
    chk("rincr", 32'(rincr), 32'(exp_rincr));
    chk("m_valid", 32'(m_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("m_data", 32'(m_data), 32'(mq[0][DATAW-1:0]));
      chk("m_last", 32'(m_last), 32'(mq[0][DATAW]));
    end
    chk("pkt_cnt", 32'(pkt_cnt), 32'(mpkt));
    chk("drop_cnt", 32'(drop_cnt), 32'(mdcnt));
    if (cyc_idx < 32) begin
      rv_log[cyc_idx] = rincr;
      mv_log[cyc_idx] = m_valid;
    end
    cyc_idx++;
    if (m_valid && m_ready) dlv.push_back({m_last, m_data});
    pend_vld = 0;
    if (rincr && src_q.size() != 0) begin
      pend     = src_q.pop_front();
      pend_vld = 1;
    end
    if (!rrst) model_clear();
    else       model_step(fl, rdy, w);
  endtask

  task automatic start_test();
    dlv.delete(); rv_log = '0; mv_log = '0; cyc_idx = 0;
  endtask

  task automatic do_reset();
    rrst = 1'b0; rempty = 1'b1;
    src_q.delete(); model_clear();
    cyc(0, 1, 0); cyc(0, 1, 0);
    rrst = 1'b1;
    start_test();
  endtask

  task automatic load_pkt(input int id, input int n);
    for (int i = 0; i < n; i++) src_q.push_back({i == n-1, 8'(id), 8'(i)});
  endtask

  // delivered stream must be exactly packet id, words 0..n-1
  task automatic chk_pkt(input string nm, input int id, input int n);
    chk({nm, "_cnt"}, 32'(dlv.size()), 32'(n));
    for (int i = 0; i < n && i < dlv.size(); i++)
      chk({nm, "_word"}, 32'(dlv[i]), 32'({i == n-1, 8'(id), 8'(i)}));
  endtask

  initial begin
    bit done;
    int len;
    model_clear();
    start_test();
    #2;
    // reset state
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_rincr", 32'(rincr), 0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    do_reset();

    // 1: back-to-back 4-word packet
    load_pkt(1, 4);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0);
    chk("t1_rincr_pattern", rv_log[7:0], 32'h0F);
    chk("t1_mvalid_pattern", mv_log[7:0], 32'h3C);
    chk("t1_pkt_cnt", 32'(pkt_cnt), 1);
    chk_pkt("t1", 1, 4);

    // 2: backpressure holds 3 words, head stable
    do_reset();
    load_pkt(2, 4);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0);
    chk("t2_pops", rv_log[9:0], 32'h007);
    chk("t2_head", 32'(m_data), 32'h0200);
    chk("t2_valid", 32'(m_valid), 1);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0);
    chk_pkt("t2", 2, 4);
    chk("t2_pkt_cnt", 32'(pkt_cnt), 1);

    // 3: flush after 2nd handshake of an 8-word packet
    do_reset();
    load_pkt(3, 8); load_pkt(4, 2);
    done = 0;
    for (int i = 0; i < 30; i++) begin
      if (dlv.size() == 2 && !done) begin
        cyc(1, 0, 0);
        done = 1;
        chk("t3_pkt_cnt_mid", 32'(pkt_cnt), 0);
      end else cyc(0, 1, 0);
    end
    chk("t3_n", 32'(dlv.size()), 4);
    if (dlv.size() == 4) begin
      chk("t3_w0", 32'(dlv[0]), 32'h00300);
      chk("t3_w1", 32'(dlv[1]), 32'h00301);
      chk("t3_w2", 32'(dlv[2]), 32'h00400);
      chk("t3_w3", 32'(dlv[3]), 32'h10401);
    end
    chk("t3_drop_cnt", 32'(drop_cnt), 1);
    chk("t3_pkt_cnt", 32'(pkt_cnt), 1);

    // 4: flush ignored once the whole packet is buffered
    do_reset();
    load_pkt(5, 2);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0);
    cyc(1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0);
    chk_pkt("t4", 5, 2);
    chk("t4_pkt_cnt", 32'(pkt_cnt), 1);
    chk("t4_drop_cnt", 32'(drop_cnt), 0);

    // 5: flush in the clk the last word arrives
    do_reset();
    load_pkt(6, 3); load_pkt(7, 2);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    cyc(1, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0);
    chk_pkt("t5", 7, 2);
    chk("t5_drop_cnt", 32'(drop_cnt), 1);
    chk("t5_pkt_cnt", 32'(pkt_cnt), 1);

    // 6: async reset mid-packet with two buffered words
    start_test();
    load_pkt(8, 4);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0);
    chk("t6_pre_valid", 32'(m_valid), 1);
    #2;
    rrst = 1'b0; rempty = 1'b1;
    #1;
    chk("t6_m_valid", 32'(m_valid), 0);
    chk("t6_pkt_cnt", 32'(pkt_cnt), 0);
    chk("t6_drop_cnt", 32'(drop_cnt), 0);
    chk("t6_rincr", 32'(rincr), 0);
    src_q.delete(); model_clear();
    cyc(0, 1, 0); cyc(0, 1, 0);
    rrst = 1'b1;
    start_test();
    load_pkt(9, 3);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0);
    chk_pkt("t6_after", 9, 3);

    // random traffic with backpressure, stalls and flushes; drives counters to saturation
    for (int i = 0; i < 4000; i++) begin
      if (src_q.size() < 8) begin
        len = $urandom_range(1, 6);
        for (int k = 0; k < len; k++)
          src_q.push_back({k == len-1, 16'($urandom)});
      end
      cyc($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 20);
    end
    chk("sat_pkt_cnt", 32'(pkt_cnt), SAT);
    chk("sat_drop_cnt", 32'(drop_cnt), SAT);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
